// File: rtl/rr_mux_n_pkg.sv
// Shared definitions for the round-robin multiplexer: select-mode encodings and
// a rotate-priority search reusable by other arbiters.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int unsigned RR_MAX_CH = 64;
    localparam int unsigned RR_IDX_W  = $clog2(RR_MAX_CH);

    // Returns the first set request at or after ptr (mod n); returns n when nothing is requested.
    function automatic int unsigned rr_first(input logic [RR_MAX_CH-1:0] req,
                                             input int unsigned n,
                                             input int unsigned ptr);
        int unsigned idx;
        int unsigned res;
        res = n;
        idx = 0;
        for (int unsigned i = 0; i < RR_MAX_CH; i++) begin
            if (i < n && res == n) begin
                idx = ptr + i;
                if (idx >= n) idx = idx - n;
                if (req[idx[RR_IDX_W-1:0]]) res = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_mux_n_if.sv
// Producer-side and consumer-side handshake bundle of rr_mux_n; slave is the mux, master the environment.
interface rr_mux_n_if #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 8,
    localparam int unsigned SW  = $clog2(N_CH)
);
    logic [N_CH*W-1:0] in_data;
    logic [N_CH-1:0]   in_valid;
    logic [N_CH-1:0]   in_ready;
    logic              mode;
    logic [SW-1:0]     sel;
    logic [W-1:0]      out_data;
    logic [SW-1:0]     out_ch;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/rr_mux_n_rr_pick.sv
// Combinational round-robin picker: first requesting channel starting at ptr, wrapping modulo N_CH.
module rr_pick
    import mux_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    localparam int unsigned SW  = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic            gnt_vld,
    output logic [SW-1:0]   gnt_idx
);

    int unsigned w_pick;

    always_comb begin
        w_pick  = rr_first(RR_MAX_CH'(req), N_CH, 32'(ptr));
        gnt_vld = (w_pick != N_CH);
        gnt_idx = SW'(w_pick);
    end

endmodule

// File: rtl/rr_mux_n.sv
// N-channel registered multiplexer with valid/ready on every port; grant is either sel-driven
// (FIXED) or round-robin (RR), feeding a single output register without skid buffer.
module rr_mux_n
    import mux_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 8,
    localparam int unsigned SW  = $clog2(N_CH)
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_mux_n_if.slave     bus
);

    logic [W-1:0]    r_out_data;
    logic [SW-1:0]   r_out_ch;
    logic            r_out_valid;
    logic [SW-1:0]   r_rr_ptr;

    logic            w_rr_vld;
    logic [SW-1:0]   w_rr_idx;
    logic            w_fix_vld;
    logic            w_gnt_vld;
    logic [SW-1:0]   w_gnt_idx;
    logic            w_load_en;
    logic            w_xfer;
    logic [N_CH-1:0] w_ready;
    logic [W-1:0]    w_data;

    rr_pick #(.N_CH(N_CH)) u_pick (
        .req     (bus.in_valid),
        .ptr     (r_rr_ptr),
        .gnt_vld (w_rr_vld),
        .gnt_idx (w_rr_idx)
    );

    // Loop compare keeps sel >= N_CH grant-free without indexing past in_valid.
    always_comb begin
        w_fix_vld = 1'b0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (32'(bus.sel) == k && bus.in_valid[k]) w_fix_vld = 1'b1;
        end
    end

    always_comb begin
        w_gnt_vld = (bus.mode == MODE_RR) ? w_rr_vld : w_fix_vld;
        w_gnt_idx = (bus.mode == MODE_RR) ? w_rr_idx : bus.sel;
        w_load_en = ~r_out_valid | bus.out_ready;
        // Held low during reset so no producer sees a handshake that the register cannot take.
        w_xfer    = w_gnt_vld & w_load_en & rst_n;
    end

    always_comb begin
        w_ready = '0;
        w_data  = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (32'(w_gnt_idx) == k) begin
                w_ready[k] = w_xfer;
                w_data     = bus.in_data[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_xfer) begin
                r_out_data  <= w_data;
                r_out_ch    <= w_gnt_idx;
                r_out_valid <= 1'b1;
                if (bus.mode == MODE_RR) begin
                    r_rr_ptr <= (w_gnt_idx == SW'(N_CH-1)) ? '0 : w_gnt_idx + 1'b1;
                end
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux_n.sv
// Scoreboard bench for rr_mux_n (N_CH=4, W=8): directed vectors push expected words, a negedge monitor pops them.
module tb_rr_mux_n;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    rr_mux_n_if #(.N_CH(4), .W(8)) bus ();

    rr_mux_n #(.N_CH(4), .W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ch, input logic [7:0] data);
        exp_t e;
        e.ch   = ch;
        e.data = data;
        sb.push_back(e);
    endtask

    // Monitor: a word leaves the DUT on every edge where out_valid & out_ready.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_unexpected: got ch%0d data 0x%0h expected no word", bus.out_ch, bus.out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_data", 32'(bus.out_data), 32'(e.data));
                check("mon_ch", 32'(bus.out_ch), 32'(e.ch));
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n        = 1'b0;
        bus.mode     = 1'b0;
        bus.sel      = 2'd0;
        bus.in_data  = {8'hDD, 8'hCC, 8'hBB, 8'h5A};
        bus.in_valid = 4'b0001;
        bus.out_ready = 1'b0;
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_out_ch", 32'(bus.out_ch), 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("t1_in_ready_pre", 32'(bus.in_ready), 32'h1);

        // Test 1: hold 0x5A, async reset discards it
        tick();
        check("t1_held_valid", 32'(bus.out_valid), 1);
        check("t1_held_data", 32'(bus.out_data), 32'h5A);
        bus.in_valid = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_async_valid", 32'(bus.out_valid), 0);
        check("t1_async_data", 32'(bus.out_data), 0);
        check("t1_async_ch", 32'(bus.out_ch), 0);
        check("t1_async_ready", 32'(bus.in_ready), 0);
        rst_n = 1'b1;
        bus.in_data   = {8'hDD, 8'hCC, 8'hBB, 8'h11};
        bus.in_valid  = 4'b0001;
        bus.out_ready = 1'b1;
        push(2'd0, 8'h11);
        tick();
        check("t1_first_valid", 32'(bus.out_valid), 1);
        check("t1_first_ch", 32'(bus.out_ch), 0);
        bus.in_valid = 4'b0000;
        tick();

        // Test 2: FIXED mode steps through sel
        bus.in_data  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            bus.sel = 2'(i);
            #1;
            check("t2_in_ready", 32'(bus.in_ready), 32'(1) << i);
            push(2'(i), 8'hAA + 8'(8'h11 * i));
            tick();
            check("t2_out_data", 32'(bus.out_data), 32'(8'hAA + 8'(8'h11 * i)));
        end
        bus.in_valid = 4'b0000;
        tick();

        // Test 3: FIXED, selected channel idle
        bus.sel      = 2'd0;
        bus.in_valid = 4'b1011;
        push(2'd0, 8'hAA);
        tick();
        bus.sel = 2'd2;
        #1;
        check("t3_in_ready", 32'(bus.in_ready), 0);
        tick();
        check("t3_drained", 32'(bus.out_valid), 0);

        // Test 4: RR fairness with all channels requesting
        bus.mode     = 1'b1;
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t4_in_ready", 32'(bus.in_ready), 32'(1) << (i % 4));
            push(2'(i % 4), 8'hAA + 8'(8'h11 * (i % 4)));
            tick();
        end
        bus.in_valid = 4'b0000;
        tick();

        // Test 5: RR sparse requests; channels and pointer hand-traced
        begin
            logic [3:0] vv [5] = '{4'b0010, 4'b0011, 4'b0011, 4'b0001, 4'b1001};
            int         gg [5] = '{1, 0, 1, 0, 3};
            for (int i = 0; i < 5; i++) begin
                bus.in_valid = vv[i];
                #1;
                check("t5_in_ready", 32'(bus.in_ready), 32'(1) << gg[i]);
                push(2'(gg[i]), 8'hAA + 8'(8'h11 * gg[i]));
                tick();
                check("t5_out_ch", 32'(bus.out_ch), 32'(gg[i]));
            end
        end
        bus.in_valid = 4'b0000;
        tick();

        // Test 6: back-pressure, then no-gap reload
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0001;
        push(2'd0, 8'hAA);
        tick();
        bus.in_valid = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t6_in_ready", 32'(bus.in_ready), 0);
            check("t6_hold_valid", 32'(bus.out_valid), 1);
            check("t6_hold_data", 32'(bus.out_data), 32'hAA);
            check("t6_hold_ch", 32'(bus.out_ch), 0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("t6_release_ready", 32'(bus.in_ready), 32'b0010);
        push(2'd1, 8'hBB);
        tick();
        check("t6_nogap_valid", 32'(bus.out_valid), 1);
        check("t6_nogap_ch", 32'(bus.out_ch), 1);
        bus.in_valid = 4'b0000;
        tick();
        tick();
        check("sb_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
